apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, PADDR width; DATA_WIDTH, default 32, PWDATA/PRDATA width; TIMEOUT, default 16, maximum ACCESS cycles before forced termination.
REQ-002 PCLK  input  1  single clock; all logic on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  request-side transfer offered.
REQ-005 req_ready  output  1  request accepted on the edge where req_valid && req_ready.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_WIDTH  transfer address.
REQ-008 req_wdata  input  DATA_WIDTH  write data, ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle pulse per completed transfer.
REQ-010 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-011 rsp_err  output  1  PSLVERR of the completed transfer, or timeout; qualified by rsp_valid.
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB control to the slave.
REQ-013 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH  APB address/data.
REQ-014 PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1  APB slave response.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-016 IDLE: PSEL=0, PENABLE=0; req_ready=1; on req_valid, latch req_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
REQ-017 SETUP: exactly one cycle, PSEL=1, PENABLE=0, req_ready=0; unconditionally go to ACCESS.
REQ-018 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable from SETUP until ACCESS exits.
REQ-019 ACCESS completes on the edge where PREADY=1; PREADY is sampled only in ACCESS.
REQ-020 On completion, the next cycle SHALL show rsp_valid=1 for one cycle, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes.
REQ-021 req_ready SHALL equal 1 combinationally in ACCESS when PREADY=1 or the timeout fires; a request accepted then SHALL go directly to SETUP (back-to-back, no IDLE cycle); otherwise ACCESS returns to IDLE.
REQ-022 Wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0; when it reaches TIMEOUT-1 with PREADY still 0, the transfer SHALL terminate: rsp_valid=1, rsp_err=1, rsp_rdata=0, next state as in REQ-021.
REQ-023 Minimum latency: acceptance edge -> SETUP 1 cycle -> ACCESS >=1 cycle -> rsp_valid on the cycle after completion (3 cycles after acceptance with zero wait states).
REQ-024 Throughput with zero wait states and continuous req_valid SHALL be one transfer per 2 cycles.
REQ-025 PREADY/PSLVERR asserted outside ACCESS SHALL be ignored.

Reset
REQ-026 PRESET=1 SHALL force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0 on the next edge.
REQ-027 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort it with no rsp_valid pulse; req_ready=0 while PRESET=1.

Structure
REQ-028 Shared package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and default width constants, for reuse by APB_Slave and the UVM environment.
REQ-029 apb_master SHALL be a single module with no sub-modules; output registers and FSM in one clocked process, req_ready as the only combinational output.

Verification
REQ-030 Write addr 0x10 data 0xDEADBEEF, slave PREADY=1 in ACCESS -> PSEL rises, PENABLE one cycle later, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-031 Write 0x20=0x12345678 then read 0x20 back-to-back against APB_Slave -> no IDLE cycle between, read rsp_rdata=0x12345678.
REQ-032 Read with PREADY held low 3 ACCESS cycles -> PADDR/PWRITE stable throughout, rsp_valid on the cycle after PREADY=1.
REQ-033 PREADY held low, TIMEOUT=16 -> termination after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0 next cycle.
REQ-034 PSLVERR=1 with PREADY on read of 0x40 -> rsp_err=1 for that response only; next transfer rsp_err=0.
REQ-035 PRESET asserted during ACCESS -> next cycle all outputs at reset values, no rsp_valid; new request after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_TIMEOUT    = 16;

  // Width of a counter that must hold values 0 .. timeout-1.
  function automatic int apb_cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: turns a valid/ready request stream into APB SETUP/ACCESS transfers.
// Latency: response pulse 3 cycles after acceptance with zero wait states; +1 per wait state.
// Backpressure: req_ready high in IDLE, or in the ACCESS cycle that completes/times out.
//
// Ports:
//   PCLK, PRESET                          clock, synchronous active-high reset
//   req_valid/req_ready/req_write/
//   req_addr/req_wdata                    request side, accepted on valid && ready
//   rsp_valid/rsp_rdata/rsp_err           one-cycle response per completed transfer
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA      APB request to the slave
//   PRDATA/PREADY/PSLVERR                 APB slave response
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = apb_cnt_width(TIMEOUT);

  apb_state_t       state;
  apb_state_t       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             xfer_done;
  logic             accept;

  // Completion/acceptance decode. req_ready is the only combinational output;
  // it opens in the finishing ACCESS cycle so a new request chains straight
  // into SETUP without an IDLE bubble.
  always_comb begin
    timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
    xfer_done   = (state == ACCESS) && (PREADY || timeout_hit);
    req_ready   = !PRESET && ((state == IDLE) || xfer_done);
    accept      = req_valid && req_ready;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done) state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, APB outputs and response are all registered here; PSEL/PENABLE
  // are derived from the next state so they line up with the phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      PSEL      <= (state_nxt != IDLE);
      PENABLE   <= (state_nxt == ACCESS);
      rsp_valid <= xfer_done;

      if (xfer_done) begin
        // On a timeout PREADY is low, so PSLVERR is not a qualified response.
        rsp_err   <= timeout_hit | PSLVERR;
        rsp_rdata <= (timeout_hit || PWRITE) ? '0 : PRDATA;
      end

      // Address/control only change on acceptance, which keeps them stable
      // from SETUP through the last ACCESS cycle.
      if (accept) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end

      if (state_nxt == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !xfer_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed corner cases followed by random traffic.
// Latency: n/a (bench).
// Backpressure: requests are held until the bench's timeline model says they are taken.
module tb_apb_master;

  localparam int TMO  = 16;
  localparam int MAXC = 20000;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;   // PREADY-low ACCESS cycles; >= TMO means never ready
    bit          err;     // PSLVERR driven with PREADY
    bit          rst;     // pulse PRESET in the second ACCESS cycle
    int          gap;     // idle cycles after previous acceptance before offering
  } plan_t;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b1;
  always #5 PCLK = ~PCLK;

  int          total = 0;
  int          bad   = 0;
  int          t     = 0;
  plan_t       plans[$];
  plan_t       cur;
  bit          busy, rsp_pending, prev_rst, rst_now, req_on, exp_ready, exp_rv, tmo, drained;
  int          c_acc, ce, rsp_t, last_evt, n_rsp, n_done;
  bit          exp_err;
  logic [31:0] exp_rd;
  logic [31:0] mem [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic add_plan(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit err, input bit rst, input int gap);
    plan_t p;
    p.wr = wr; p.addr = addr; p.wdata = wdata; p.waits = waits;
    p.err = err; p.rst = rst; p.gap = gap;
    plans.push_back(p);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // Directed cases.
    add_plan(1, 32'h10, 32'hDEADBEEF, 0,       0, 0, 0);  // basic write
    add_plan(1, 32'h20, 32'h12345678, 0,       0, 0, 2);  // write ...
    add_plan(0, 32'h20, $urandom,     0,       0, 0, 0);  // ... read back-to-back
    add_plan(0, 32'h20, $urandom,     3,       0, 0, 1);  // 3 wait states
    add_plan(0, 32'h30, $urandom,     TMO,     0, 0, 0);  // never ready -> timeout
    add_plan(0, 32'h40, $urandom,     0,       1, 0, 3);  // slave error
    add_plan(0, 32'h40, $urandom,     0,       0, 0, 0);  // error clears
    add_plan(1, 32'h44, 32'hA5A5A5A5, 4,       0, 1, 1);  // reset mid-ACCESS, write lost
    add_plan(0, 32'h44, $urandom,     0,       0, 0, 2);  // old value still there
    add_plan(1, 32'h08, 32'hCAFEF00D, TMO - 1, 0, 0, 0);  // ready on the last allowed cycle
    add_plan(0, 32'h08, $urandom,     0,       0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      int r, w;
      r = $urandom_range(0, 9);
      w = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : (($urandom_range(0, 1) == 0) ? TMO : TMO - 1);
      add_plan($urandom_range(0, 1), 32'($urandom_range(0, 31) * 4), $urandom, w,
               $urandom_range(0, 5) == 0, (w >= 2) && ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    busy = 0; rsp_pending = 0; prev_rst = 0; req_on = 0; drained = 0;
    c_acc = 0; ce = 0; rsp_t = 0; last_evt = 3; n_rsp = 0; n_done = 0;
    exp_err = 0; exp_rd = '0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0; PRESET = 1;

    #1;
    while (t < MAXC && !drained) begin
      // ---- drive inputs for cycle t ----
      rst_now = (t < 3) || (busy && cur.rst && (t == c_acc + 3));
      PRESET  = rst_now;

      if (!req_on && plans.size() > 0 && (t > last_evt + plans[0].gap)) req_on = 1;
      if (req_on) begin
        req_valid = 1;
        req_write = plans[0].wr;
        req_addr  = plans[0].addr;
        req_wdata = plans[0].wdata;
      end else begin
        req_valid = 0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end

      if (busy && t >= c_acc + 2) begin
        bit rdy;
        rdy     = (t == ce) && (cur.waits < TMO);
        PREADY  = rdy;
        PSLVERR = rdy ? cur.err : 1'($urandom);
        PRDATA  = (rdy && !cur.wr) ? mem[cur.addr[6:2]] : $urandom;
      end else begin
        // Noise outside ACCESS must be ignored.
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end

      // ---- sample outputs for cycle t ----
      @(negedge PCLK);
      exp_ready = !rst_now && (!busy || t == ce);
      exp_rv    = rsp_pending && (rsp_t == t);
      if (t >= 1) begin
        chk("req_ready", req_ready, exp_ready);
        chk("psel",      PSEL,      busy);
        chk("penable",   PENABLE,   busy && (t >= c_acc + 2));
        chk("rsp_valid", rsp_valid, exp_rv);
        if (rsp_valid) n_rsp++;
        if (exp_rv) begin
          chk("rsp_err",   rsp_err,   exp_err);
          chk("rsp_rdata", rsp_rdata, exp_rd);
          rsp_pending = 0;
        end
        if (busy) begin
          chk("paddr",  PADDR,  cur.addr);
          chk("pwrite", PWRITE, cur.wr);
          if (cur.wr) chk("pwdata", PWDATA, cur.wdata);
        end
        if (prev_rst) begin
          chk("rst_paddr",  PADDR,     0);
          chk("rst_pwrite", PWRITE,    0);
          chk("rst_pwdata", PWDATA,    0);
          chk("rst_err",    rsp_err,   0);
          chk("rst_rdata",  rsp_rdata, 0);
        end
      end

      // ---- model the edge at the end of cycle t ----
      prev_rst = rst_now;
      if (rst_now) begin
        busy        = 0;
        rsp_pending = 0;
      end else begin
        if (busy && t == ce) begin
          tmo         = (cur.waits >= TMO);
          rsp_pending = 1;
          rsp_t       = t + 1;
          exp_err     = tmo ? 1'b1 : cur.err;
          exp_rd      = (tmo || cur.wr) ? 32'h0 : mem[cur.addr[6:2]];
          if (!tmo && cur.wr && !cur.err) mem[cur.addr[6:2]] = cur.wdata;
          busy = 0;
          n_done++;
        end
        if (req_on && exp_ready) begin
          cur      = plans.pop_front();
          c_acc    = t;
          ce       = (cur.waits >= TMO) ? t + 1 + TMO : t + 2 + cur.waits;
          busy     = 1;
          req_on   = 0;
          last_evt = t;
        end
      end
      drained = (plans.size() == 0) && !req_on && !busy && !rsp_pending && (t > 4);

      @(posedge PCLK);
      #1;
      t++;
    end

    chk("drained", drained, 1);
    chk("rsp_count", n_rsp, n_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
